// File: rtl/hack_alu_pkg.sv
// rtl/hack_alu_pkg.sv - Hack ALU width, control-bit indices and canonical opcodes
package hack_alu_pkg;

    localparam int WIDTH = 16;

    localparam int ZX = 5;
    localparam int NX = 4;
    localparam int ZY = 3;
    localparam int NY = 2;
    localparam int F  = 1;
    localparam int NO = 0;

    typedef logic [5:0] alu_ctrl_t;

    localparam alu_ctrl_t OP_ZERO    = 6'b101010;
    localparam alu_ctrl_t OP_ONE     = 6'b111111;
    localparam alu_ctrl_t OP_NEG_ONE = 6'b111010;
    localparam alu_ctrl_t OP_X       = 6'b001100;
    localparam alu_ctrl_t OP_Y       = 6'b110000;
    localparam alu_ctrl_t OP_X_ADD_Y = 6'b000010;
    localparam alu_ctrl_t OP_X_SUB_Y = 6'b010011;
    localparam alu_ctrl_t OP_Y_SUB_X = 6'b000111;
    localparam alu_ctrl_t OP_X_AND_Y = 6'b000000;
    localparam alu_ctrl_t OP_X_OR_Y  = 6'b010101;

endpackage

// File: rtl/hack_alu_core.sv
// rtl/hack_alu_core.sv - combinational Hack ALU datapath: preset, AND/ADD, optional negate
module hack_alu_core
    import hack_alu_pkg::*;
#(
    parameter int WIDTH = hack_alu_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  alu_ctrl_t        signal,
    output logic [WIDTH-1:0] res,
    output logic             c
);

    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] x2;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] y2;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;

    always_comb begin
        x1  = signal[ZX] ? '0 : x;
        x2  = signal[NX] ? ~x1 : x1;
        y1  = signal[ZY] ? '0 : y;
        y2  = signal[NY] ? ~y1 : y1;
        sum = {1'b0, x2} + {1'b0, y2};
        r   = '0;
        c   = 1'b0;
        if (signal[F]) begin
            r = sum[WIDTH-1:0];
            c = sum[WIDTH];
        end else begin
            r = x2 & y2;
        end
        // carry reflects the raw adder, so output negation must not touch it
        res = signal[NO] ? ~r : r;
    end

endmodule

// File: rtl/hack_alu.sv
// rtl/hack_alu.sv - registered Hack ALU top; zr/ng flags exist only with HACK_ALU_FLAGS_EN
module hack_alu
    import hack_alu_pkg::*;
#(
    parameter int WIDTH = hack_alu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       signal,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             cout,
`ifdef HACK_ALU_FLAGS_EN
    output logic             zr,
    output logic             ng,
`endif
    output logic             out_valid
);

    logic [WIDTH-1:0] res;
    logic             c;

    hack_alu_core #(.WIDTH(WIDTH)) u_core (
        .x      (x),
        .y      (y),
        .signal (signal),
        .res    (res),
        .c      (c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out  <= res;
                cout <= c;
            end
        end
    end

`ifdef HACK_ALU_FLAGS_EN
    // reset state mirrors out==0: zero flag set, negative flag clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zr <= 1'b1;
            ng <= 1'b0;
        end else if (in_valid) begin
            zr <= (res == '0);
            ng <= res[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_hack_alu.sv
// tb/tb_hack_alu.sv - directed self-checking bench for hack_alu (zr/ng checked with HACK_ALU_FLAGS_EN)
module tb_hack_alu;
    import hack_alu_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] x;
    logic [15:0] y;
    logic [5:0]  signal;
    logic        in_valid;
    logic [15:0] out;
    logic        cout;
    logic        out_valid;
    logic        zr;
    logic        ng;
    int          checks;
    int          errors;

    hack_alu #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .y         (y),
        .signal    (signal),
        .in_valid  (in_valid),
        .out       (out),
        .cout      (cout),
`ifdef HACK_ALU_FLAGS_EN
        .zr        (zr),
        .ng        (ng),
`endif
        .out_valid (out_valid)
    );

`ifndef HACK_ALU_FLAGS_EN
    assign zr = 1'b0;
    assign ng = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic [15:0] xv, input logic [15:0] yv, input logic [5:0] sv, input logic v);
        x        = xv;
        y        = yv;
        signal   = sv;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (out !== 16'h0000) begin errors++; $display("FAIL reset_out got=%h exp=0000", out); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
`ifdef HACK_ALU_FLAGS_EN
        checks++; if (zr !== 1'b1) begin errors++; $display("FAIL reset_zr got=%b exp=1", zr); end
        checks++; if (ng !== 1'b0) begin errors++; $display("FAIL reset_ng got=%b exp=0", ng); end
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        step(16'h0045, 16'h0045, OP_X_ADD_Y, 1'b1);
        checks++; if (out !== 16'h008A) begin errors++; $display("FAIL add_45_45 got=%h exp=008A", out); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL add_45_45_cout got=%b exp=0", cout); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", out_valid); end
        step(16'h0045, 16'h0040, OP_X_ADD_Y, 1'b1);
        checks++; if (out !== 16'h0085) begin errors++; $display("FAIL add_45_40 got=%h exp=0085", out); end
        step(16'hFFFF, 16'h0001, OP_X_ADD_Y, 1'b1);
        checks++; if (out !== 16'h0000) begin errors++; $display("FAIL add_wrap got=%h exp=0000", out); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL add_wrap_cout got=%b exp=1", cout); end
`ifdef HACK_ALU_FLAGS_EN
        checks++; if (zr !== 1'b1) begin errors++; $display("FAIL add_wrap_zr got=%b exp=1", zr); end
        checks++; if (ng !== 1'b0) begin errors++; $display("FAIL add_wrap_ng got=%b exp=0", ng); end
`endif
    endtask

    task automatic test_sub();
        step(16'h0005, 16'h0003, OP_X_SUB_Y, 1'b1);
        checks++; if (out !== 16'h0002) begin errors++; $display("FAIL x_sub_y got=%h exp=0002", out); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL x_sub_y_cout got=%b exp=0", cout); end
        step(16'h0005, 16'h0003, OP_Y_SUB_X, 1'b1);
        checks++; if (out !== 16'hFFFE) begin errors++; $display("FAIL y_sub_x got=%h exp=FFFE", out); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL y_sub_x_cout got=%b exp=1", cout); end
`ifdef HACK_ALU_FLAGS_EN
        checks++; if (ng !== 1'b1) begin errors++; $display("FAIL y_sub_x_ng got=%b exp=1", ng); end
        checks++; if (zr !== 1'b0) begin errors++; $display("FAIL y_sub_x_zr got=%b exp=0", zr); end
`endif
    endtask

    task automatic test_canonical();
        logic [5:0]  ops [7];
        logic [15:0] exp_out [7];
        logic        exp_c [7];
        ops[0] = OP_X_AND_Y; exp_out[0] = 16'h00F0; exp_c[0] = 1'b0;
        ops[1] = OP_ZERO;    exp_out[1] = 16'h0000; exp_c[1] = 1'b0;
        ops[2] = OP_ONE;     exp_out[2] = 16'h0001; exp_c[2] = 1'b1;
        ops[3] = OP_NEG_ONE; exp_out[3] = 16'hFFFF; exp_c[3] = 1'b0;
        ops[4] = OP_X;       exp_out[4] = 16'h00F0; exp_c[4] = 1'b0;
        ops[5] = OP_Y;       exp_out[5] = 16'h0FF0; exp_c[5] = 1'b0;
        ops[6] = OP_X_OR_Y;  exp_out[6] = 16'h0FF0; exp_c[6] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(16'h00F0, 16'h0FF0, ops[i], 1'b1);
            checks++; if (out !== exp_out[i]) begin errors++; $display("FAIL canon_op%b got=%h exp=%h", ops[i], out, exp_out[i]); end
            checks++; if (cout !== exp_c[i]) begin errors++; $display("FAIL canon_op%b_cout got=%b exp=%b", ops[i], cout, exp_c[i]); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL canon_valid got=%b exp=1", out_valid); end
`ifdef HACK_ALU_FLAGS_EN
            checks++; if (zr !== (exp_out[i] == 16'h0000)) begin errors++; $display("FAIL canon_op%b_zr got=%b", ops[i], zr); end
            checks++; if (ng !== exp_out[i][15]) begin errors++; $display("FAIL canon_op%b_ng got=%b", ops[i], ng); end
`endif
        end
    endtask

    task automatic test_hold();
        step(16'h1234, 16'h0001, OP_X_ADD_Y, 1'b1);
        checks++; if (out !== 16'h1235) begin errors++; $display("FAIL hold_load got=%h exp=1235", out); end
        step(16'hFFFF, 16'hFFFF, OP_X_ADD_Y, 1'b0);
        checks++; if (out !== 16'h1235) begin errors++; $display("FAIL hold_out got=%h exp=1235", out); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL hold_cout got=%b exp=0", cout); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_valid got=%b exp=0", out_valid); end
        step(16'hFFFF, 16'hFFFF, OP_X_ADD_Y, 1'b0);
        checks++; if (out !== 16'h1235) begin errors++; $display("FAIL hold_out2 got=%h exp=1235", out); end
    endtask

    task automatic test_async_reset();
        step(16'h0045, 16'h0045, OP_X_ADD_Y, 1'b1);
        checks++; if (out !== 16'h008A) begin errors++; $display("FAIL prereset_out got=%h exp=008A", out); end
        x = 16'hFFFF; y = 16'h0001; signal = OP_X_ADD_Y; in_valid = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        checks++; if (out !== 16'h0000) begin errors++; $display("FAIL areset_out got=%h exp=0000", out); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL areset_cout got=%b exp=0", cout); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%b exp=0", out_valid); end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++; if (out !== 16'h0000) begin errors++; $display("FAIL postreset_out%0d got=%h exp=0000", i, out); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL postreset_valid%0d got=%b exp=0", i, out_valid); end
`ifdef HACK_ALU_FLAGS_EN
            checks++; if (zr !== 1'b1) begin errors++; $display("FAIL postreset_zr%0d got=%b exp=1", i, zr); end
`endif
        end
        step(16'h0003, 16'h0004, OP_X_ADD_Y, 1'b1);
        checks++; if (out !== 16'h0007) begin errors++; $display("FAIL first_after_reset got=%h exp=0007", out); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_after_reset_valid got=%b exp=1", out_valid); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        x        = '0;
        y        = '0;
        signal   = '0;
        in_valid = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_canonical();
        test_hold();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
